// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - shared constants and helpers for the dff_pipe delay line
package dff_pipe_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Saturating increment: the retire counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one {valid, data} pipeline register; scan path under DFF_PIPE_SCAN_EN
module dff_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
`ifdef DFF_PIPE_SCAN_EN
    input  logic             shift,
    input  logic             scan_in,
`endif
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // Priority: reset, then clear, then scan shift (data only, valid holds), then normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
`ifdef DFF_PIPE_SCAN_EN
        else if (shift) begin
            // Shift toward the MSB; the shift form also works for WIDTH=1.
            data_q <= (data_q << 1) | WIDTH'(scan_in);
        end
`endif
        else if (load) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage valid/data delay line with occupancy and retire counter; optional scan via DFF_PIPE_SCAN_EN
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           d,
`ifdef DFF_PIPE_SCAN_EN
    input  logic                       scan_en,
    input  logic                       scan_in,
    output logic                       scan_out,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           capture_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic             load;
    logic [OCC_W-1:0] occ_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef DFF_PIPE_SCAN_EN
    // Scan shifting takes over from normal advance; flush still wins inside each stage.
    assign load     = en & ~scan_en;
    assign scan_out = stage_data[DEPTH-1][WIDTH-1];
`else
    assign load = en;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] din;
`ifdef DFF_PIPE_SCAN_EN
        logic             sin;
`endif
        if (i == 0) begin : g_head
            assign vin = in_valid;
            assign din = d;
`ifdef DFF_PIPE_SCAN_EN
            assign sin = scan_in;
`endif
        end else begin : g_body
            assign vin = stage_valid[i-1];
            assign din = stage_data[i-1];
`ifdef DFF_PIPE_SCAN_EN
            assign sin = stage_data[i-1][WIDTH-1];
`endif
        end

        dff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .clear   (flush),
`ifdef DFF_PIPE_SCAN_EN
            .shift   (scan_en),
            .scan_in (sin),
`endif
            .valid_d (vin),
            .data_d  (din),
            .valid_q (stage_valid[i]),
            .data_q  (stage_data[i])
        );
    end

    // Occupancy tracks the valid population incrementally: one may enter and one may leave per advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (load) begin
            occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(stage_valid[DEPTH-1]);
        end
    end

    // Count a retirement whenever an advancing edge pushes a valid sample out of the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!flush && load && stage_valid[DEPTH-1]) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign q           = stage_data[DEPTH-1];
    assign out_valid   = stage_valid[DEPTH-1];
    assign occupancy   = occ_q;
    assign capture_cnt = cnt_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - self-checking bench for dff_pipe; scan checks when DFF_PIPE_SCAN_EN is defined
module tb_dff_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  d = 8'h00;
    logic [7:0]  q;
    logic        out_valid;
    logic [2:0]  occupancy;
    logic [15:0] capture_cnt;

    int total = 0;
    int bad = 0;

`ifdef DFF_PIPE_SCAN_EN
    logic        m_scan_out;
    logic        s_en = 1'b0;
    logic        s_inv = 1'b0;
    logic [3:0]  s_d = 4'h0;
    logic        s_scan_en = 1'b0;
    logic        s_scan_in = 1'b0;
    logic        s_scan_out;
    logic [3:0]  s_q;
    logic        s_ov;
    logic [1:0]  s_occ;
    logic [15:0] s_cnt;
`endif

    dff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .in_valid    (in_valid),
        .d           (d),
`ifdef DFF_PIPE_SCAN_EN
        .scan_en     (1'b0),
        .scan_in     (1'b0),
        .scan_out    (m_scan_out),
`endif
        .q           (q),
        .out_valid   (out_valid),
        .occupancy   (occupancy),
        .capture_cnt (capture_cnt)
    );

`ifdef DFF_PIPE_SCAN_EN
    dff_pipe #(.WIDTH(4), .DEPTH(2)) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (s_en),
        .flush       (1'b0),
        .in_valid    (s_inv),
        .d           (s_d),
        .scan_en     (s_scan_en),
        .scan_in     (s_scan_in),
        .scan_out    (s_scan_out),
        .q           (s_q),
        .out_valid   (s_ov),
        .occupancy   (s_occ),
        .capture_cnt (s_cnt)
    );
`endif

    typedef struct {
        logic        en;
        logic        flush;
        logic        inv;
        logic [7:0]  d;
        logic [7:0]  q;
        logic        ov;
        logic [2:0]  occ;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic eov,
                             input logic [2:0] eocc, input logic [15:0] ecnt);
        chk({tag, "_q"},   64'(q),           64'(eq));
        chk({tag, "_ov"},  64'(out_valid),   64'(eov));
        chk({tag, "_occ"}, 64'(occupancy),   64'(eocc));
        chk({tag, "_cnt"}, 64'(capture_cnt), 64'(ecnt));
    endtask

    // One clock period; inputs are set while clk is low, outputs are read when this returns.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    // Change d in the same timestep as the rising edge, ahead of clk.
    task automatic tick_race(input logic [7:0] v);
        #5;
        d   = v;
        clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 3'd1, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 3'd1, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 16'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 3'd1, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 3'd2, 16'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 3'd3, 16'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h44, 8'h11, 1'b1, 3'd4, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h11, 1'b1, 3'd4, 16'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h11, 1'b1, 3'd4, 16'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h11, 1'b1, 3'd4, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0, 3'd0, 16'd1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'hC1, 8'h00, 1'b0, 3'd1, 16'd1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 8'hC2, 8'h00, 1'b0, 3'd2, 16'd1};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, 3'd3, 16'd1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 8'hC4, 8'hC1, 1'b1, 3'd4, 16'd1};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 8'hEE, 8'h00, 1'b0, 3'd0, 16'd1};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0, 3'd1, 16'd1};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd1, 16'd1};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 16'd1};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 8'h6B, 8'h00, 1'b0, 3'd2, 16'd1};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 3'd2, 16'd1};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 16'd2};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h6B, 1'b1, 3'd1, 16'd2};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 16'd3};

        // Reset state, reached without any clock edge.
        #3;
        chk_state("reset", 8'h00, 1'b0, 3'd0, 16'd0);
        #2 rst_n = 1'b1;

        // Table-driven sequence: latency, hold, flush with and without en, bubbles.
        for (int i = 0; i < 26; i++) begin
            en       = tbl[i].en;
            flush    = tbl[i].flush;
            in_valid = tbl[i].inv;
            d        = tbl[i].d;
            tick();
            chk_state($sformatf("vec%0d", i), tbl[i].q, tbl[i].ov, tbl[i].occ, tbl[i].cnt);
        end
        flush = 1'b0;

        // Same-timestep input change ahead of the edge must be captured at the new value.
        en = 1'b1; in_valid = 1'b1; d = 8'h00;
        tick_race(8'hFF);
        tick_race(8'h00);
        in_valid = 1'b0; d = 8'h00;
        tick();
        tick();
        chk_state("race_e4", 8'hFF, 1'b1, 3'd2, 16'd3);
        tick();
        chk_state("race_e5", 8'h00, 1'b1, 3'd1, 16'd4);
        tick();
        chk_state("race_e6", 8'h00, 1'b0, 3'd0, 16'd5);

        // Asynchronous reset with three samples in flight.
        in_valid = 1'b0; d = 8'h7E; tick();
        in_valid = 1'b1; d = 8'h81; tick();
        d = 8'h82; tick();
        d = 8'h83; tick();
        chk_state("prerst", 8'h7E, 1'b0, 3'd3, 16'd5);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 1'b0, 3'd0, 16'd0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; d = 8'h3C;
        tick();
        chk_state("post_rst1", 8'h00, 1'b0, 3'd1, 16'd0);
        in_valid = 1'b0; d = 8'h00;
        tick(); tick(); tick();
        chk_state("post_rst4", 8'h3C, 1'b1, 3'd1, 16'd0);

`ifdef DFF_PIPE_SCAN_EN
        begin
            logic [7:0] pat;
            pat = 8'b1011_0010;
            s_en = 1'b1; s_inv = 1'b1; s_d = 4'hF;
            tick();
            s_inv = 1'b0; s_d = 4'h0;
            s_scan_en = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                s_scan_in = pat[i];
                tick();
            end
            chk("scan_stage1", 64'(s_q), 64'(4'hB));
            chk("scan_stage0", 64'(u_scan.g_stage[0].u_stage.data_q), 64'(4'h2));
            chk("scan_occ", 64'(s_occ), 64'(2'd1));
            chk("scan_ov", 64'(s_ov), 64'(1'b0));
            chk("scan_cnt", 64'(s_cnt), 64'(16'd0));
            s_scan_in = 1'b0;
            for (int i = 7; i >= 0; i--) begin
                chk($sformatf("scan_out%0d", i), 64'(s_scan_out), 64'(pat[i]));
                tick();
            end
            s_scan_en = 1'b0; s_en = 1'b0;
        end
`endif

        // Saturation: drive the retire counter up to FFFE, then retire three more.
        en = 1'b1; in_valid = 1'b1; d = 8'hA0;
        for (int i = 0; i < 70000 && capture_cnt != 16'hFFFE; i++) begin
            tick();
        end
        chk("sat_reach", 64'(capture_cnt), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_%0d", i), 64'(capture_cnt), 64'(16'hFFFF));
            chk($sformatf("sat_ov%0d", i), 64'(out_valid), 64'(1'b1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per stage, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of pipeline stages, legal range 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; 0 holds all state.
REQ-006 The block SHALL have port flush, input, 1 bit: clears all valid bits.
REQ-007 The block SHALL have port in_valid, input, 1 bit: d carries a sample.
REQ-008 The block SHALL have port d, input, WIDTH bits: input data.
REQ-009 The block SHALL have port q, output, WIDTH bits: last-stage data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: last-stage valid.
REQ-011 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.
REQ-012 The block SHALL have port capture_cnt, output, 16 bits: number of samples retired from the last stage.

Function
REQ-013 On a rising clk edge with en=1 and flush=0, the block SHALL load stage 0 with {in_valid, d} and load stage i with stage i-1, for i=1..DEPTH-1.
REQ-014 On a rising edge with en=0 and flush=0, the block SHALL keep every stage, occupancy and capture_cnt unchanged.
REQ-015 Latency SHALL be exactly DEPTH enabled edges: a sample taken at enabled edge N appears on q/out_valid after enabled edge N+DEPTH-1 is complete.
REQ-016 q and out_valid SHALL be driven directly from the last stage's registers, with no combinational path from d, in_valid, en or flush.
REQ-017 On a rising edge with flush=1, the block SHALL clear all valid bits and zero all data regardless of en, and SHALL NOT load stage 0 with in_valid or d.
REQ-018 flush SHALL have priority over en, and SHALL leave capture_cnt unchanged.
REQ-019 Each edge SHALL sample d and in_valid as their values at the moment of the edge; an input changed in the same timestep as the posedge, when the bench assigns the input before clk, SHALL be captured at its new value.
REQ-020 occupancy SHALL equal the population count of the stage valid bits, registered so that it is consistent with those bits after every edge; its range SHALL be 0..DEPTH.
REQ-021 capture_cnt SHALL increment by 1 on each enabled, non-flush edge at which out_valid=1 before the edge.
REQ-022 capture_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-023 When DEPTH=1, stage 0 SHALL be the last stage and latency SHALL be 1 edge.

Reset
REQ-024 While rst_n=0, the block SHALL force all stage data, all valid bits, occupancy and capture_cnt to 0 immediately, without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight samples.
REQ-026 When rst_n deasserts, the first rising edge on which rst_n=1 SHALL operate normally.

Configuration
REQ-027 With DFF_PIPE_SCAN_EN defined, the block SHALL add three ports: scan_en input 1 bit, scan_in input 1 bit, scan_out output 1 bit.
REQ-028 With DFF_PIPE_SCAN_EN defined and scan_en=1, all DEPTH*WIDTH data bits SHALL shift one bit per edge, from scan_in through stage 0 bit 0 up to the last stage bit WIDTH-1 and out on scan_out.
REQ-029 During scan shifting, valid bits, occupancy and capture_cnt SHALL hold, and scan_en SHALL override en but not flush or reset.
REQ-030 Without DFF_PIPE_SCAN_EN, the scan ports and scan logic SHALL be absent and behaviour SHALL be exactly REQ-013..REQ-026.

Structure
REQ-031 Package dff_pipe_pkg SHALL hold the capture counter width (16), its saturation constant, and the default WIDTH and DEPTH values.
REQ-032 Sub-module dff_stage, one stage register holding {valid, data} with load, clear, async reset and an optional scan path, SHALL be instantiated DEPTH times via generate.

Verification
REQ-033 The bench SHALL cover this scenario: WIDTH=8, DEPTH=4, en=1, in_valid=1, d=8'hA5 at edge 1, then in_valid=0 -> q=8'hA5 with out_valid=1 after edge 4, capture_cnt=1 after edge 5.
REQ-034 The bench SHALL cover this scenario: d changes 8'h00->8'hFF in the same timestep as the posedge, assigned before clk -> 8'hFF is captured; then d changes 8'hFF->8'h00 at the same moment as a later posedge -> 8'h00 is captured.
REQ-035 The bench SHALL cover this scenario: fill all 4 stages, then assert en=0 for 3 edges -> q, occupancy=4 and capture_cnt are unchanged; assert flush=1 with en=0 -> occupancy=0 and out_valid=0 after 1 edge.
REQ-036 The bench SHALL cover this scenario: drop rst_n between edges with 3 stages valid -> occupancy=0, q=0 and capture_cnt=0 without any clk edge; the first edge after release loads stage 0.
REQ-037 The bench SHALL cover this scenario: preload capture_cnt to 16'hFFFE, then retire 3 valid samples -> capture_cnt=16'hFFFF and holds.
REQ-038 The bench SHALL cover this scenario: with DFF_PIPE_SCAN_EN, WIDTH=4, DEPTH=2, shift in 8'b1011_0010 over 8 edges with scan_en=1 -> stage contents match, and the next 8 edges reproduce the same pattern on scan_out.
